// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state codes,
// opcodes, datapath mux encodings and the bundled control-word type.
// The ORI_ZERO_EXT_EN macro adds ORI (zero-extended immediate) to the dispatch.
package mips_ctrl_pkg;

  localparam int OP_W = 6;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // next-PC source
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       branch;
    logic       pc_write;
    logic       ext_op;
    logic       illegal_op;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  // Quiescent control word: nothing written, sign-extension selected.
  localparam ctrl_t CTRL_IDLE = '{
    iord:       1'b0,
    mem_write:  1'b0,
    ir_write:   1'b0,
    reg_dst:    1'b0,
    mem_to_reg: 1'b0,
    reg_write:  1'b0,
    alu_src_a:  1'b0,
    branch:     1'b0,
    pc_write:   1'b0,
    ext_op:     1'b1,
    illegal_op: 1'b0,
    alu_src_b:  SRCB_REG,
    alu_op:     ALUOP_ADD,
    pc_src:     PCSRC_ALU
  };

  // State entered from DECODE; FETCH means the opcode is not supported.
  function automatic state_t dispatch_state(input logic [OP_W-1:0] op);
    state_t s;
    case (op)
      OP_LW, OP_SW: s = S_MEMADR;
      OP_RTYPE:     s = S_EXECUTE;
      OP_BEQ:       s = S_BRANCH;
      OP_ADDI:      s = S_IMMEX;
      OP_J:         s = S_JUMP;
`ifdef ORI_ZERO_EXT_EN
      OP_ORI:       s = S_IMMEX;
`endif
      default:      s = S_FETCH;
    endcase
    return s;
  endfunction

  function automatic logic opcode_legal(input logic [OP_W-1:0] op);
    return dispatch_state(op) != S_FETCH;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle. master = control unit, slave = datapath.
interface multicycle_control_unit_if #(
  parameter int OPCODE_WIDTH = 6,
  parameter int STATE_WIDTH  = 4
);

  logic [OPCODE_WIDTH-1:0] Opcode;
  logic                    Zero;
  logic                    Mem_Ready;

  logic                    IorD;
  logic                    MemWrite;
  logic                    IRWrite;
  logic                    RegDst;
  logic                    MemtoReg;
  logic                    RegWrite;
  logic                    ALUSrcA;
  logic                    Branch;
  logic                    PCWrite;
  logic                    PCEn;
  logic                    ExtOp;
  logic                    Illegal_Op;
  logic [1:0]              ALUSrcB;
  logic [1:0]              ALUOp;
  logic [1:0]              PCSrc;
  logic [STATE_WIDTH-1:0]  State_Out;

  modport master (
    input  Opcode, Zero, Mem_Ready,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           Branch, PCWrite, PCEn, ExtOp, Illegal_Op, ALUSrcB, ALUOp, PCSrc,
           State_Out
  );

  modport slave (
    output Opcode, Zero, Mem_Ready,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           Branch, PCWrite, PCEn, ExtOp, Illegal_Op, ALUSrcB, ALUOp, PCSrc,
           State_Out
  );

endinterface

// File: rtl/multicycle_control_unit_decoder.sv
// control_output_decoder: pure combinational map from the current state
// (plus Mem_Ready and opcode) to the datapath control word.
// With ORI_ZERO_EXT_EN defined, IMMEX for ORI selects zero-extension and OR.
module control_output_decoder
  import mips_ctrl_pkg::*;
(
  input  state_t          state,
  input  logic            mem_ready,
  input  logic [OP_W-1:0] opcode,
  output ctrl_t           ctrl
);

  // per-state control word; unused codes fall through to the idle word
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_FETCH: begin
        ctrl.alu_src_b = SRCB_FOUR;
        // IR and PC only latch once the instruction word has arrived
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.illegal_op = !opcode_legal(opcode);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_IMMEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
`ifdef ORI_ZERO_EXT_EN
        // opcode is stable here: the IR is only written in FETCH
        if (opcode == OP_ORI) begin
          ctrl.ext_op = 1'b0;
          ctrl.alu_op = ALUOP_OR;
        end
`endif
      end
      S_IMMWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode and the
// per-instruction execute/memory/writeback steps.
// Optional ORI_ZERO_EXT_EN macro enables ORI through the IMMEX/IMMWB path.
//
// state   | meaning
// --------+-----------------------------------------------
// FETCH   | read instruction, PC+4; waits for Mem_Ready
// DECODE  | register read, branch target; dispatch on opcode
// MEMADR  | compute load/store address
// MEMRD   | load data read; waits for Mem_Ready
// MEMWB   | write loaded data to register file
// MEMWR   | store data write; waits for Mem_Ready
// EXECUTE | R-type ALU operation
// ALUWB   | write R-type result (rd)
// BRANCH  | BEQ compare, conditional PC update
// IMMEX   | immediate ALU operation (ADDI, ORI)
// IMMWB   | write immediate result (rt)
// JUMP    | unconditional PC update
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = 6,
  parameter int STATE_WIDTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  multicycle_control_unit_if.master bus
);

  state_t                  state_q;
  state_t                  state_d;
  logic [OPCODE_WIDTH-1:0] opcode_in;
  logic [OP_W-1:0]         opcode_w;
  ctrl_t                   ctrl_raw;
  ctrl_t                   ctrl_out;
  logic [STATE_WIDTH-1:0]  state_out;

  assign opcode_in = bus.Opcode;
  assign opcode_w  = OP_W'(opcode_in);

  // state register; reset is synchronous and may abort any instruction
  always_ff @(posedge CLK) begin
    if (!RST) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (bus.Mem_Ready) state_d = S_DECODE;
      S_DECODE:  state_d = dispatch_state(opcode_w);
      S_MEMADR:  state_d = (opcode_w == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (bus.Mem_Ready) state_d = S_MEMWB;
      S_MEMWR:   if (bus.Mem_Ready) state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
      S_IMMEX:   state_d = S_IMMWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP: state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  control_output_decoder u_decoder (
    .state     (state_q),
    .mem_ready (bus.Mem_Ready),
    .opcode    (opcode_w),
    .ctrl      (ctrl_raw)
  );

  // outputs, held quiescent while reset is asserted even before the edge
  always_comb begin
    ctrl_out  = ctrl_raw;
    state_out = STATE_WIDTH'(state_q);
    if (!RST) begin
      ctrl_out  = CTRL_IDLE;
      state_out = '0;
    end
  end

  assign bus.IorD       = ctrl_out.iord;
  assign bus.MemWrite   = ctrl_out.mem_write;
  assign bus.IRWrite    = ctrl_out.ir_write;
  assign bus.RegDst     = ctrl_out.reg_dst;
  assign bus.MemtoReg   = ctrl_out.mem_to_reg;
  assign bus.RegWrite   = ctrl_out.reg_write;
  assign bus.ALUSrcA    = ctrl_out.alu_src_a;
  assign bus.Branch     = ctrl_out.branch;
  assign bus.PCWrite    = ctrl_out.pc_write;
  assign bus.ExtOp      = ctrl_out.ext_op;
  assign bus.Illegal_Op = ctrl_out.illegal_op;
  assign bus.ALUSrcB    = ctrl_out.alu_src_b;
  assign bus.ALUOp      = ctrl_out.alu_op;
  assign bus.PCSrc      = ctrl_out.pc_src;
  assign bus.State_Out  = state_out;
  assign bus.PCEn       = ctrl_out.pc_write | (ctrl_out.branch & bus.Zero);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. Honours ORI_ZERO_EXT_EN.
module tb_multicycle_control_unit;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  int   n;

  multicycle_control_unit_if #(.OPCODE_WIDTH(6), .STATE_WIDTH(4)) bus ();

  multicycle_control_unit #(.OPCODE_WIDTH(6), .STATE_WIDTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic c1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic c2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic c4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic ci(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance one clock, then drive Mem_Ready for the new cycle and settle
  task automatic step(input logic mr);
    @(posedge CLK);
    #1;
    bus.Mem_Ready = mr;
    #1;
  endtask

  // from FETCH with Mem_Ready=1, count cycles until FETCH again (bounded)
  task automatic run_lat(output int cnt);
    cnt = 0;
    do begin
      step(1'b1);
      cnt++;
    end while (bus.State_Out != 4'd0 && cnt < 20);
  endtask

  initial begin
    RST           = 1'b0;
    bus.Mem_Ready = 1'b0;
    bus.Zero      = 1'b0;
    bus.Opcode    = 6'h00;

    // reset: everything quiet, even with Mem_Ready high
    step(1'b0);
    c4("rst_state", bus.State_Out, 4'd0);
    c2("rst_srcb", bus.ALUSrcB, 2'b00);
    c1("rst_extop", bus.ExtOp, 1'b1);
    c1("rst_pcen", bus.PCEn, 1'b0);
    bus.Mem_Ready = 1'b1;
    #1;
    c1("rst_pcwrite_mr", bus.PCWrite, 1'b0);
    c1("rst_irwrite_mr", bus.IRWrite, 1'b0);
    bus.Mem_Ready = 1'b0;
    step(1'b0);

    // release reset, FETCH stalls while memory not ready
    RST = 1'b1;
    #1;
    c4("fetch_state", bus.State_Out, 4'd0);
    c2("fetch_srcb", bus.ALUSrcB, 2'b01);
    c1("fetch_stall_irw", bus.IRWrite, 1'b0);
    c1("fetch_stall_pcw", bus.PCWrite, 1'b0);
    step(1'b0);
    c4("fetch_hold", bus.State_Out, 4'd0);

    // LW walk with one MEMRD stall
    bus.Opcode    = 6'h23;
    bus.Mem_Ready = 1'b1;
    #1;
    c1("fetch_irw", bus.IRWrite, 1'b1);
    c1("fetch_pcw", bus.PCWrite, 1'b1);
    c1("fetch_pcen", bus.PCEn, 1'b1);
    step(1'b1);
    c4("lw_decode", bus.State_Out, 4'd1);
    c2("decode_srcb", bus.ALUSrcB, 2'b11);
    c1("lw_legal", bus.Illegal_Op, 1'b0);
    step(1'b1);
    c4("lw_memadr", bus.State_Out, 4'd2);
    c1("memadr_srca", bus.ALUSrcA, 1'b1);
    c2("memadr_srcb", bus.ALUSrcB, 2'b10);
    step(1'b0);
    c4("lw_memrd", bus.State_Out, 4'd3);
    c1("memrd_iord", bus.IorD, 1'b1);
    c1("memrd_regw", bus.RegWrite, 1'b0);
    step(1'b1);
    c4("lw_memrd_hold", bus.State_Out, 4'd3);
    step(1'b1);
    c4("lw_memwb", bus.State_Out, 4'd4);
    c1("memwb_regw", bus.RegWrite, 1'b1);
    c1("memwb_m2r", bus.MemtoReg, 1'b1);
    step(1'b1);
    c4("lw_back", bus.State_Out, 4'd0);
    c1("lw_back_regw", bus.RegWrite, 1'b0);
    c1("lw_back_m2r", bus.MemtoReg, 1'b0);

    // latencies with Mem_Ready held high
    bus.Opcode = 6'h23; run_lat(n); ci("lat_lw", n, 5);
    bus.Opcode = 6'h2B; run_lat(n); ci("lat_sw", n, 4);
    bus.Opcode = 6'h00; run_lat(n); ci("lat_r", n, 4);
    bus.Opcode = 6'h08; run_lat(n); ci("lat_addi", n, 4);
    bus.Opcode = 6'h04; run_lat(n); ci("lat_beq", n, 3);
    bus.Opcode = 6'h02; run_lat(n); ci("lat_j", n, 3);

    // R-type
    bus.Opcode = 6'h00;
    step(1'b1);
    step(1'b1);
    c4("r_exec", bus.State_Out, 4'd6);
    c2("exec_aluop", bus.ALUOp, 2'b10);
    c1("exec_srca", bus.ALUSrcA, 1'b1);
    step(1'b1);
    c4("r_aluwb", bus.State_Out, 4'd7);
    c1("aluwb_regdst", bus.RegDst, 1'b1);
    c1("aluwb_regw", bus.RegWrite, 1'b1);
    step(1'b1);

    // ADDI: sign-extended add
    bus.Opcode = 6'h08;
    step(1'b1);
    step(1'b1);
    c4("addi_immex", bus.State_Out, 4'd9);
    c1("addi_extop", bus.ExtOp, 1'b1);
    c2("addi_aluop", bus.ALUOp, 2'b00);
    c2("addi_srcb", bus.ALUSrcB, 2'b10);
    step(1'b1);
    c4("addi_immwb", bus.State_Out, 4'd10);
    c1("immwb_regw", bus.RegWrite, 1'b1);
    step(1'b1);

    // J
    bus.Opcode = 6'h02;
    step(1'b1);
    step(1'b1);
    c4("j_jump", bus.State_Out, 4'd11);
    c2("j_pcsrc", bus.PCSrc, 2'b10);
    c1("j_pcen", bus.PCEn, 1'b1);
    step(1'b1);
    c4("j_back", bus.State_Out, 4'd0);

    // BEQ taken / not taken
    bus.Opcode = 6'h04;
    bus.Zero   = 1'b1;
    step(1'b1);
    step(1'b1);
    c4("beq_branch", bus.State_Out, 4'd8);
    c2("beq_pcsrc", bus.PCSrc, 2'b01);
    c2("beq_aluop", bus.ALUOp, 2'b01);
    c1("beq_pcwrite", bus.PCWrite, 1'b0);
    c1("beq_pcen_z1", bus.PCEn, 1'b1);
    step(1'b1);
    bus.Zero = 1'b0;
    step(1'b1);
    step(1'b1);
    c1("beq_branch_z0", bus.Branch, 1'b1);
    c1("beq_pcen_z0", bus.PCEn, 1'b0);
    step(1'b1);
    c4("beq_back", bus.State_Out, 4'd0);

    // SW with two not-ready cycles in MEMWR: 6 cycles total
    bus.Opcode = 6'h2B;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    c4("sw_memwr1", bus.State_Out, 4'd5);
    c1("sw_memw1", bus.MemWrite, 1'b1);
    c1("sw_iord1", bus.IorD, 1'b1);
    c1("sw_stall_pcw", bus.PCWrite, 1'b0);
    c1("sw_stall_regw", bus.RegWrite, 1'b0);
    step(1'b0);
    c4("sw_memwr2", bus.State_Out, 4'd5);
    c1("sw_memw2", bus.MemWrite, 1'b1);
    step(1'b1);
    c4("sw_memwr3", bus.State_Out, 4'd5);
    c1("sw_memw3", bus.MemWrite, 1'b1);
    step(1'b1);
    c4("sw_back", bus.State_Out, 4'd0);
    c1("sw_back_memw", bus.MemWrite, 1'b0);

    // illegal opcode: one-cycle pulse in DECODE, then FETCH
    bus.Opcode = 6'h3F;
    step(1'b1);
    c4("ill_decode", bus.State_Out, 4'd1);
    c1("ill_pulse", bus.Illegal_Op, 1'b1);
    c1("ill_regw", bus.RegWrite, 1'b0);
    c1("ill_memw", bus.MemWrite, 1'b0);
    c1("ill_pcw", bus.PCWrite, 1'b0);
    step(1'b1);
    c4("ill_back", bus.State_Out, 4'd0);
    c1("ill_clear", bus.Illegal_Op, 1'b0);

    // ORI
    bus.Opcode = 6'h0D;
    step(1'b1);
`ifdef ORI_ZERO_EXT_EN
    c1("ori_legal", bus.Illegal_Op, 1'b0);
    step(1'b1);
    c4("ori_immex", bus.State_Out, 4'd9);
    c1("ori_extop", bus.ExtOp, 1'b0);
    c2("ori_aluop", bus.ALUOp, 2'b11);
    step(1'b1);
    c4("ori_immwb", bus.State_Out, 4'd10);
    c1("ori_regw", bus.RegWrite, 1'b1);
    c1("ori_wb_extop", bus.ExtOp, 1'b1);
    step(1'b1);
`else
    c1("ori_illegal", bus.Illegal_Op, 1'b1);
    c1("ori_extop", bus.ExtOp, 1'b1);
    step(1'b1);
`endif
    c4("ori_back", bus.State_Out, 4'd0);

    // reset asserted mid-load in MEMRD
    bus.Opcode = 6'h23;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    c4("mid_memrd", bus.State_Out, 4'd3);
    RST = 1'b0;
    #1;
    c4("mid_rst_state", bus.State_Out, 4'd0);
    c1("mid_rst_iord", bus.IorD, 1'b0);
    c1("mid_rst_extop", bus.ExtOp, 1'b1);
    c1("mid_rst_pcen", bus.PCEn, 1'b0);
    step(1'b1);
    c4("mid_rst_state2", bus.State_Out, 4'd0);
    c1("mid_rst_pcw", bus.PCWrite, 1'b0);
    c1("mid_rst_irw", bus.IRWrite, 1'b0);
    RST = 1'b1;
    #1;
    c4("rel_state", bus.State_Out, 4'd0);
    c1("rel_pcw", bus.PCWrite, 1'b1);
    c2("rel_srcb", bus.ALUSrcB, 2'b01);
    step(1'b1);
    c4("rel_decode", bus.State_Out, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 6, width of the instruction opcode field.
REQ-002 SHALL have parameter STATE_WIDTH, default 4, width of the state register and debug port.
REQ-003 SHALL have port CLK input 1: single clock, all state changes on the rising edge.
REQ-004 SHALL have port RST input 1: reset, synchronous, active-low.
REQ-005 SHALL have port Opcode input OPCODE_WIDTH: Instr[31:26] from the instruction register.
REQ-006 SHALL have port Zero input 1: ALU zero flag.
REQ-007 SHALL have port Mem_Ready input 1: memory access completes this cycle.
REQ-008 SHALL have 1-bit outputs IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite, PCEn, ExtOp, Illegal_Op.
REQ-009 SHALL have 2-bit outputs ALUSrcB, ALUOp, PCSrc.
REQ-010 SHALL have output State_Out STATE_WIDTH: current state, for debug.

Function
REQ-011 SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11; codes 12-15 SHALL go to FETCH.
REQ-012 Opcode decoding: LW 0x23, SW 0x2B, R-type 0x00, BEQ 0x04, ADDI 0x08, J 0x02.
REQ-013 Transitions: FETCH->DECODE only when Mem_Ready=1, else hold. DECODE->MEMADR (LW/SW), EXECUTE (R), BRANCH (BEQ), IMMEX (ADDI), JUMP (J). MEMADR->MEMRD (LW) or MEMWR (SW). MEMRD->MEMWB only when Mem_Ready=1, else hold. MEMWR->FETCH only when Mem_Ready=1, else hold. EXECUTE->ALUWB. IMMEX->IMMWB. MEMWB, ALUWB, BRANCH, IMMWB and JUMP each go to FETCH.
REQ-014 An unlisted opcode in DECODE SHALL assert Illegal_Op for exactly that one cycle, and the next state SHALL be FETCH.
REQ-015 Outputs SHALL default to 0 (ExtOp defaults to 1 = sign-extend). Per state, only the listed outputs are driven:
- FETCH: ALUSrcB=01; IRWrite=PCWrite=Mem_Ready.
- DECODE: ALUSrcB=11.
- MEMADR: ALUSrcA=1, ALUSrcB=10.
- MEMRD: IorD=1.
- MEMWB: MemtoReg=1, RegWrite=1.
- MEMWR: IorD=1, MemWrite=1.
- EXECUTE: ALUSrcA=1, ALUOp=10.
- ALUWB: RegDst=1, RegWrite=1.
- BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1.
- IMMEX: ALUSrcA=1, ALUSrcB=10.
- IMMWB: RegWrite=1.
- JUMP: PCSrc=10, PCWrite=1.
REQ-016 SHALL drive PCEn = PCWrite | (Branch & Zero) combinationally.
REQ-017 Latency with Mem_Ready held at 1: LW 5 cycles; SW, R-type and ADDI 4 cycles; BEQ and J 3 cycles, each measured from FETCH back to FETCH.
REQ-018 Each Mem_Ready=0 cycle in FETCH, MEMRD or MEMWR SHALL add exactly one cycle and SHALL assert no write strobe in that cycle.
REQ-019 State_Out SHALL equal the state register.

Reset
REQ-020 RST=0 sampled at a rising edge SHALL load FETCH, including mid-instruction.
REQ-021 While RST=0, all outputs SHALL be forced to 0 (ExtOp=1, State_Out=0), and no write strobe or PCEn SHALL be asserted.

Configuration
REQ-022 Macro ORI_ZERO_EXT_EN, when defined, SHALL decode ORI (0x0D) as DECODE->IMMEX->IMMWB, with ExtOp=0 and ALUOp=11 in IMMEX, giving 4-cycle latency.
REQ-023 When ORI_ZERO_EXT_EN is not defined, 0x0D SHALL be illegal per REQ-014, and ExtOp SHALL be constant 1.

Structure
REQ-024 Package mips_ctrl_pkg SHALL hold the state encodings, opcode constants, and the ALUSrcB/ALUOp/PCSrc encodings.
REQ-025 Sub-module control_output_decoder SHALL map state, Mem_Ready and Opcode to the REQ-015 outputs as pure combinational logic; the top module holds the state register and next-state logic.

Verification
REQ-026 LW 0x23 with Mem_Ready=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in MEMWB.
REQ-027 BEQ 0x04 with Zero=1 -> PCEn=1 in BRANCH with PCSrc=01. Same with Zero=0 -> PCEn=0.
REQ-028 SW 0x2B with Mem_Ready=0 for 2 cycles in MEMWR -> MemWrite held, total 6 cycles, FETCH afterward.
REQ-029 Opcode 0x3F -> Illegal_Op pulse of 1 cycle in DECODE, then FETCH; RegWrite, MemWrite and PCWrite stay 0.
REQ-030 RST=0 asserted during MEMRD -> FETCH next edge; all outputs 0 while low. Releasing RST -> FETCH with PCWrite=1 once Mem_Ready=1.
REQ-031 ORI 0x0D -> with ORI_ZERO_EXT_EN: ExtOp=0 and ALUOp=11 in IMMEX, RegWrite in IMMWB. Without the macro: Illegal_Op.
